// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32 subset datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every
// datapath strobe and select. It also owns the memory handshake, a memory-wait
// watchdog, an illegal-opcode trap and the retired-instruction counter.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ins,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             RegWrite,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alu_src,
  output logic [1:0]       alu_op,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd7
  } state_e;

  // BEQ and BNE are separate classes so EXEC needs nothing from ins.
  typedef enum logic [2:0] {
    ClsR, ClsI, ClsLw, ClsSw, ClsBeq, ClsBne, ClsJal
  } cls_e;

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d, dec_cls;
  logic [1:0]       cause_q, cause_d;
  logic [7:0]       wait_q;
  logic [CNT_W-1:0] instret_q;
  logic             dec_ok;
  logic             wait_hit;
  logic             unused_ins;

  assign unused_ins = ^{ins[31:15], ins[11:7]};

  // This cycle's wait would bring the count up to the timeout.
  assign wait_hit = ({1'b0, wait_q} + 9'd1) == 9'(MEM_TIMEOUT);

  // Classify the opcode held in IR.
  always_comb begin
    dec_cls = ClsR;
    dec_ok  = 1'b1;
    case (ins[6:0])
      7'b0110011: dec_cls = ClsR;
      7'b0010011: dec_cls = ClsI;
      7'b0000011: dec_cls = ClsLw;
      7'b0100011: dec_cls = ClsSw;
      7'b1100011: begin
        if (ins[14:12] == 3'b000) begin
          dec_cls = ClsBeq;
        end else if (ins[14:12] == 3'b001) begin
          dec_cls = ClsBne;
        end else begin
          dec_ok = 1'b0;
        end
      end
      7'b1101111: dec_cls = ClsJal;
      default:    dec_ok  = 1'b0;
    endcase
  end

  // Next state, latched class and trap cause.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cause_d = cause_q;
    case (state_q)
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (wait_hit) begin
          state_d = StTrap;
          cause_d = 2'd2;
        end
      end
      StDecode: begin
        cls_d = dec_cls;
        if (dec_ok) begin
          state_d = StExec;
        end else begin
          state_d = StTrap;
          cause_d = 2'd1;
        end
      end
      StExec: begin
        unique case (cls_q)
          ClsLw, ClsSw:          state_d = StMem;
          ClsBeq, ClsBne, ClsJal: state_d = StFetch;
          default:               state_d = StWb;
        endcase
      end
      StMem: begin
        if (mem_ready) begin
          state_d = (cls_q == ClsLw) ? StWb : StFetch;
        end else if (wait_hit) begin
          state_d = StTrap;
          cause_d = 2'd2;
        end
      end
      StWb:    state_d = StFetch;
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

  // Strobes and selects; forced low while reset is asserted.
  always_comb begin
    mem_req   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    RegWrite  = 1'b0;
    wb_sel    = 2'd0;
    alu_src   = 2'd0;
    alu_op    = 2'd0;
    pc_write  = 1'b0;
    pc_sel    = 2'd0;
    if (!reset) begin
      case (state_q)
        StFetch: begin
          mem_req  = 1'b1;
          mem_read = 1'b1;
          ir_write = mem_ready;
        end
        StExec: begin
          case (cls_q)
            ClsR: alu_op = 2'b10;
            ClsI: begin
              alu_src = 2'd1;
              alu_op  = 2'b11;
            end
            ClsLw: alu_src = 2'd1;
            ClsSw: alu_src = 2'd2;
            ClsBeq, ClsBne: begin
              alu_op   = 2'b01;
              pc_write = 1'b1;
              pc_sel   = (zero ^ (cls_q == ClsBne)) ? 2'd1 : 2'd0;
            end
            ClsJal: begin
              RegWrite = 1'b1;
              wb_sel   = 2'd2;
              pc_write = 1'b1;
              pc_sel   = 2'd2;
            end
            default: ;
          endcase
        end
        StMem: begin
          mem_req   = 1'b1;
          mem_read  = (cls_q == ClsLw);
          mem_write = (cls_q == ClsSw);
          alu_src   = (cls_q == ClsSw) ? 2'd2 : 2'd1;
          pc_write  = (cls_q == ClsSw) && mem_ready;
        end
        StWb: begin
          RegWrite = 1'b1;
          pc_write = 1'b1;
          wb_sel   = (cls_q == ClsLw) ? 2'd1 : 2'd0;
        end
        default: ;
      endcase
    end
  end

  // State, watchdog and retirement counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      cls_q     <= ClsR;
      cause_q   <= 2'd0;
      wait_q    <= 8'd0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cause_q <= cause_d;
      if (state_d != state_q) begin
        wait_q <= 8'd0;
      end else if (mem_req && !mem_ready) begin
        wait_q <= wait_q + 8'd1;
      end
      // One pc_write per instruction marks its retirement.
      if (pc_write) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign state      = state_q;
  assign trap       = (state_q == StTrap);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl.
module tb_multicycle_ctrl;

  localparam int unsigned T = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ins = 32'h0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_read, mem_write, ir_write, RegWrite, pc_write, trap;
  logic [1:0]  wb_sel, alu_src, alu_op, pc_sel, trap_cause;
  logic [2:0]  state;
  logic [31:0] instret;

  int checks = 0;
  int failures = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .ins(ins), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .RegWrite(RegWrite), .wb_sel(wb_sel), .alu_src(alu_src), .alu_op(alu_op),
    .pc_write(pc_write), .pc_sel(pc_sel), .state(state), .trap(trap),
    .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    zero = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if ({mem_req, mem_read, mem_write, ir_write, RegWrite, pc_write} !== 6'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=000000",
        {mem_req, mem_read, mem_write, ir_write, RegWrite, pc_write}); end
    checks++; if ({trap, trap_cause} !== 3'b0) begin failures++; $display("FAIL reset_trap got=%b exp=000", {trap, trap_cause}); end
    checks++; if (instret !== 32'd0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", instret); end
  endtask

  // R-type with zero-wait memory: 0,1,2,4,0.
  task automatic test_rtype();
    apply_reset();
    ins = 32'h002081B3; mem_ready = 1'b1; #1;
    checks++; if ({state, mem_req, ir_write} !== {3'd0, 2'b11}) begin failures++; $display("FAIL r_fetch got=%b exp=00011", {state, mem_req, ir_write}); end
    tick();
    checks++; if ({state, RegWrite} !== {3'd1, 1'b0}) begin failures++; $display("FAIL r_decode got=%b exp=0010", {state, RegWrite}); end
    tick();
    checks++; if ({state, alu_src, alu_op, RegWrite, pc_write} !== {3'd2, 2'd0, 2'b10, 2'b00}) begin
      failures++; $display("FAIL r_exec got=%b exp=010001000", {state, alu_src, alu_op, RegWrite, pc_write}); end
    tick();
    checks++; if ({state, RegWrite, wb_sel, pc_write, pc_sel} !== {3'd4, 1'b1, 2'd0, 1'b1, 2'd0}) begin
      failures++; $display("FAIL r_wb got=%b exp=100100100", {state, RegWrite, wb_sel, pc_write, pc_sel}); end
    tick();
    checks++; if ({state, instret} !== {3'd0, 32'd1}) begin failures++; $display("FAIL r_retire state=%0d instret=%0d exp 0/1", state, instret); end
  endtask

  // LW with mem_ready arriving on the third cycle of FETCH and of MEM.
  task automatic test_load();
    int cyc;
    apply_reset();
    ins = 32'h0000A103; mem_ready = 1'b0; cyc = 0;
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2); #1;
      checks++; if ({mem_req, mem_read, mem_write, ir_write} !== {3'b110, (i == 2)}) begin
        failures++; $display("FAIL lw_fetch%0d got=%b", i, {mem_req, mem_read, mem_write, ir_write}); end
      tick(); cyc++;
    end
    mem_ready = 1'b0;
    tick(); cyc++;
    checks++; if ({state, alu_src, alu_op} !== {3'd2, 2'd1, 2'd0}) begin failures++; $display("FAIL lw_exec got=%b exp=0100100", {state, alu_src, alu_op}); end
    tick(); cyc++;
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2); #1;
      checks++; if ({state, mem_req, mem_read, mem_write, pc_write} !== {3'd3, 4'b1100}) begin
        failures++; $display("FAIL lw_mem%0d got=%b exp=0111100", i, {state, mem_req, mem_read, mem_write, pc_write}); end
      tick(); cyc++;
    end
    mem_ready = 1'b0;
    checks++; if ({state, RegWrite, wb_sel, pc_write} !== {3'd4, 1'b1, 2'd1, 1'b1}) begin
      failures++; $display("FAIL lw_wb got=%b exp=1001011", {state, RegWrite, wb_sel, pc_write}); end
    tick(); cyc++;
    checks++; if ({state, instret} !== {3'd0, 32'd1} || cyc != 9) begin
      failures++; $display("FAIL lw_retire state=%0d instret=%0d cycles=%0d exp 0/1/9", state, instret, cyc); end
  endtask

  // BEQ taken, BEQ not taken, BNE taken, back to back.
  task automatic test_branch();
    logic [31:0] iv [3] = '{32'h00208463, 32'h00208463, 32'h00209463};
    logic        zv [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  sv [3] = '{2'd1, 2'd0, 2'd1};
    apply_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ins = iv[i]; zero = zv[i];
      tick(); tick();
      checks++; if ({state, alu_op, pc_write, pc_sel} !== {3'd2, 2'b01, 1'b1, sv[i]}) begin
        failures++; $display("FAIL br%0d_exec got=%b exp=%b", i, {state, alu_op, pc_write, pc_sel}, {3'd2, 2'b01, 1'b1, sv[i]}); end
      tick();
      checks++; if ({state, instret} !== {3'd0, 32'(i + 1)}) begin
        failures++; $display("FAIL br%0d_retire state=%0d instret=%0d exp 0/%0d", i, state, instret, i + 1); end
    end
  endtask

  task automatic test_jal();
    apply_reset();
    ins = 32'h008000EF; mem_ready = 1'b1;
    tick(); tick();
    checks++; if ({state, RegWrite, wb_sel, pc_write, pc_sel} !== {3'd2, 1'b1, 2'd2, 1'b1, 2'd2}) begin
      failures++; $display("FAIL jal_exec got=%b exp=010110110", {state, RegWrite, wb_sel, pc_write, pc_sel}); end
    tick();
    checks++; if ({state, instret} !== {3'd0, 32'd1}) begin failures++; $display("FAIL jal_next state=%0d instret=%0d exp 0/1", state, instret); end
  endtask

  // SW with zero-wait memory retires from MEM in 4 cycles.
  task automatic test_store();
    apply_reset();
    ins = 32'h0020A023; mem_ready = 1'b1;
    tick(); tick();
    checks++; if ({state, alu_src, alu_op} !== {3'd2, 2'd2, 2'd0}) begin failures++; $display("FAIL sw_exec got=%b exp=0101000", {state, alu_src, alu_op}); end
    tick();
    checks++; if ({state, mem_req, mem_read, mem_write, pc_write, pc_sel} !== {3'd3, 4'b1011, 2'd0}) begin
      failures++; $display("FAIL sw_mem got=%b exp=011101100", {state, mem_req, mem_read, mem_write, pc_write, pc_sel}); end
    tick();
    checks++; if ({state, instret} !== {3'd0, 32'd1}) begin failures++; $display("FAIL sw_retire state=%0d instret=%0d exp 0/1", state, instret); end
  endtask

  task automatic test_illegal();
    logic [31:0] iv [2] = '{32'h0000007F, 32'h0020A463};
    for (int i = 0; i < 2; i++) begin
      apply_reset();
      ins = iv[i]; mem_ready = 1'b1;
      tick(); tick();
      checks++; if ({state, trap, trap_cause} !== {3'd7, 1'b1, 2'd1}) begin
        failures++; $display("FAIL ill%0d_trap got=%b exp=111101", i, {state, trap, trap_cause}); end
      tick(); tick();
      checks++; if ({state, mem_req, pc_write, RegWrite, ir_write, trap_cause} !== {3'd7, 4'b0, 2'd1}) begin
        failures++; $display("FAIL ill%0d_hold got=%b exp=111000001", i, {state, mem_req, pc_write, RegWrite, ir_write, trap_cause}); end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < int'(T); i++) begin
      #1;
      checks++; if ({state, mem_req} !== {3'd0, 1'b1}) begin failures++; $display("FAIL to_wait%0d got=%b exp=0001", i, {state, mem_req}); end
      tick();
    end
    checks++; if ({state, trap, trap_cause, mem_req} !== {3'd7, 1'b1, 2'd2, 1'b0}) begin
      failures++; $display("FAIL to_trap got=%b exp=1111100", {state, trap, trap_cause, mem_req}); end
  endtask

  // Completion on the boundary cycle wins over the watchdog.
  task automatic test_timeout_boundary();
    apply_reset();
    ins = 32'h002081B3; mem_ready = 1'b0;
    for (int i = 0; i < int'(T) - 1; i++) tick();
    mem_ready = 1'b1;
    tick();
    checks++; if ({state, trap} !== {3'd1, 1'b0}) begin failures++; $display("FAIL tob_state got=%b exp=0010", {state, trap}); end
  endtask

  task automatic test_reset_mid_store();
    apply_reset();
    ins = 32'h002081B3; mem_ready = 1'b1;
    repeat (4) tick();
    ins = 32'h0020A023;
    repeat (3) tick();
    mem_ready = 1'b0; #1;
    checks++; if ({state, mem_write, instret} !== {3'd3, 1'b1, 32'd1}) begin
      failures++; $display("FAIL rst_pre state=%0d mem_write=%b instret=%0d exp 3/1/1", state, mem_write, instret); end
    reset = 1'b1; #1;
    checks++; if ({state, mem_req, mem_write, instret} !== {3'd0, 2'b00, 32'd0}) begin
      failures++; $display("FAIL rst_mid state=%0d mem_req=%b mem_write=%b instret=%0d exp 0/0/0/0", state, mem_req, mem_write, instret); end
    tick();
    reset = 1'b0; ins = 32'h002081B3; mem_ready = 1'b1; #1;
    checks++; if ({state, mem_req, mem_read} !== {3'd0, 2'b11}) begin failures++; $display("FAIL rst_resume got=%b exp=00011", {state, mem_req, mem_read}); end
    tick();
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL rst_decode got=%0d exp=1", state); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_branch();
    test_jal();
    test_store();
    test_illegal();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
